// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit feeding the register-file write port directly.
// Optional MDU_SIGNED_EN enables RV32M signed MULH/MULHSU/DIV/REM; otherwise they alias to unsigned.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [AW-1:0]    RD,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    output logic             BUSY,
    output logic             DONE,
    output logic             WE3,
    output logic [AW-1:0]    A3,
    output logic [WIDTH-1:0] WD3
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     wd_q, wd_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
`ifdef MDU_SIGNED_EN
    logic                 neg_q, neg_d;
    logic                 neg_in, a_neg, b_neg;

    always_comb begin
        a_neg  = 1'b0;
        b_neg  = 1'b0;
        neg_in = 1'b0;
        case (OP)
            3'b001: begin
                a_neg  = SRC_A[WIDTH-1];
                b_neg  = SRC_B[WIDTH-1];
                neg_in = a_neg ^ b_neg;
            end
            3'b010: begin
                a_neg  = SRC_A[WIDTH-1];
                neg_in = a_neg;
            end
            3'b100: begin
                a_neg  = SRC_A[WIDTH-1];
                b_neg  = SRC_B[WIDTH-1];
                // Divide by zero must stay all ones, so never negate that quotient.
                neg_in = (a_neg ^ b_neg) && (SRC_B != '0);
            end
            3'b110: begin
                a_neg  = SRC_A[WIDTH-1];
                b_neg  = SRC_B[WIDTH-1];
                neg_in = a_neg;
            end
            default: ;
        endcase
        a_mag = a_neg ? -SRC_A : SRC_A;
        b_mag = b_neg ? -SRC_B : SRC_B;
    end
`else
    assign a_mag = SRC_A;
    assign b_mag = SRC_B;
`endif

    // Multiply: acc = {partial, multiplier}, shift right. Divide: acc = {remainder, dividend}, shift left.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   res_src;
    logic [WIDTH-1:0]     res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_diff = div_sh[WIDTH-1:0] - opb_q;
        if (op_q[2]) begin
            acc_step = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end

        res_src = acc_step;
`ifdef MDU_SIGNED_EN
        if (neg_q && !op_q[2]) res_src = -acc_step;
`endif
        if (!op_q[2]) begin
            res = (op_q[1:0] == 2'b00) ? res_src[WIDTH-1:0] : res_src[2*WIDTH-1:WIDTH];
        end else begin
            res = op_q[1] ? res_src[2*WIDTH-1:WIDTH] : res_src[WIDTH-1:0];
        end
`ifdef MDU_SIGNED_EN
        if (neg_q && op_q[2]) res = -res;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        wd_d    = wd_q;
`ifdef MDU_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StRun;
                    cnt_d   = CW'(WIDTH);
                    op_d    = OP;
                    rd_d    = RD;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    opb_d   = b_mag;
`ifdef MDU_SIGNED_EN
                    neg_d   = neg_in;
`endif
                end
            end
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StWb;
                    wd_d    = res;
                end
            end
            StWb: begin
                state_d = StIdle;
                wd_d    = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            wd_q    <= '0;
`ifdef MDU_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            wd_q    <= wd_d;
`ifdef MDU_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign BUSY = (state_q != StIdle);
    assign DONE = (state_q == StWb);
    assign WE3  = DONE && (rd_q != '0);
    assign A3   = DONE ? rd_q : '0;
    assign WD3  = wd_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expectations from a behavioural arithmetic model.
module tb_mdu_iter;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [2:0]  OP;
    logic [4:0]  RD;
    logic [31:0] SRC_A;
    logic [31:0] SRC_B;
    logic        BUSY;
    logic        DONE;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    mdu_iter #(.WIDTH(32), .AW(5)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .RD    (RD),
        .SRC_A (SRC_A),
        .SRC_B (SRC_B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .WE3   (WE3),
        .A3    (A3),
        .WD3   (WD3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        p  = {32'b0, a} * {32'b0, b};
        sp = '0;
        sq = '0;
        case (op)
            3'b000: return p[31:0];
`ifdef MDU_SIGNED_EN
            3'b001: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp[63:32];
            end
            3'b010: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return sp[63:32];
            end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sq = $signed(a) / $signed(b);
                return sq;
            end
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sq = $signed(a) % $signed(b);
                return sq;
            end
`endif
            default: begin
                if (!op[2]) return p[63:32];
                if (op[1]) return (b == 32'h0) ? a : a % b;
                return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            end
        endcase
    endfunction

    // Every DONE must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (DONE) begin
            exp_t e;
            done_cnt++;
            check_eq("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("wd3", WD3, e.data);
                check_eq("a3", A3, e.rd);
                check_eq("we3", WE3, e.rd != 5'd0);
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int extra_start_at);
        int lat;
        @(negedge CLK);
        OP    = op;
        RD    = rd;
        SRC_A = a;
        SRC_B = b;
        START = 1'b1;
        sb_q.push_back({rd, model(op, a, b)});
        @(negedge CLK);
        START = 1'b0;
        OP    = 3'($urandom);
        RD    = 5'($urandom);
        SRC_A = $urandom;
        SRC_B = $urandom;
        lat   = 1;
        check_eq("busy_run", BUSY, 1);
        while (!DONE && lat < 60) begin
            @(negedge CLK);
            lat++;
            START = (lat == extra_start_at);
        end
        START = 1'b0;
        check_eq("latency", lat, 33);
        @(negedge CLK);
        check_eq("busy_after", BUSY, 0);
        check_eq("done_after", DONE, 0);
        check_eq("wd3_after", WD3, 0);
    endtask

    initial begin
        int d0;
        RST   = 1'b1;
        START = 1'b0;
        OP    = '0;
        RD    = '0;
        SRC_A = '0;
        SRC_B = '0;
        repeat (2) @(negedge CLK);
        check_eq("rst_outs", {BUSY, DONE, WE3, A3, WD3}, 0);
        RST = 1'b0;

        run_op(3'b000, 5'd5, 32'd7, 32'd6, 0);
        run_op(3'b011, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b000, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b101, 5'd3, 32'd100, 32'd7, 0);
        run_op(3'b111, 5'd4, 32'd100, 32'd7, 0);
        run_op(3'b101, 5'd6, 32'd5, 32'd0, 0);
        run_op(3'b111, 5'd7, 32'd5, 32'd0, 0);
        run_op(3'b000, 5'd0, 32'd3, 32'd3, 0);

        d0 = done_cnt;
        run_op(3'b000, 5'd9, 32'd11, 32'd13, 10);
        repeat (40) @(negedge CLK);
        check_eq("ignored_start", done_cnt - d0, 1);

        // Abort mid-divide.
        d0 = done_cnt;
        @(negedge CLK);
        OP    = 3'b101;
        RD    = 5'd8;
        SRC_A = 32'd1000;
        SRC_B = 32'd3;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(negedge CLK);
        RST = 1'b1;
        #1;
        check_eq("abort_busy", BUSY, 0);
        check_eq("abort_done", DONE, 0);
        check_eq("abort_we3", WE3, 0);
        check_eq("abort_wd3", WD3, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check_eq("abort_no_done", done_cnt - d0, 0);
        run_op(3'b101, 5'd8, 32'd1000, 32'd3, 0);

`ifdef MDU_SIGNED_EN
        run_op(3'b100, 5'd10, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'b110, 5'd11, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'b100, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b110, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 5'd14, 32'hFFFF_FFEC, 32'd0, 0);
        run_op(3'b110, 5'd15, 32'hFFFF_FFEC, 32'd0, 0);
        run_op(3'b001, 5'd16, 32'hFFFF_FFFE, 32'd3, 0);
        run_op(3'b010, 5'd17, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
`else
        run_op(3'b100, 5'd10, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'b110, 5'd11, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'b001, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`endif

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), ra, rb, 0);
        end

        repeat (4) @(negedge CLK);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
